ecall_io_ctrl: RTL
==================

Name: ecall_io_ctrl

Overview:
- Environment-call I/O controller, directly downstream of the instruction decoder/register file.
- Detects ECALL (instruction 32'h00000073) and reads the a7 and a0 values that the decoder supplies.
- Service 4 (print int): drives a0 to the LED/segment output.
- Service 5 (read int): samples board switches and returns the value for write-back into x10.
- Stalls PC advance until the user presses a debounced confirm button.

Parameters:
- SW_WIDTH, 16: number of switch inputs.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a button level is accepted.
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  current instruction word.
- a7  in  32  register x17 value from the decoder.
- a0_data  in  32  decoder numRe2; equals x10 during ECALL with a7 of 4 or 5.
- sw  in  SW_WIDTH  raw board switches.
- confirm_btn  in  1  raw, asynchronous confirm push-button.
- pc_stall  out  1  holds PC and blocks normal register write-back.
- io_wen  out  1  one-cycle write strobe for x10.
- io_wdata  out  32  value to write into x10.
- led_data  out  32  latched print value.
- led_valid  out  1  high while led_data shows a service-4 result.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous): state IDLE. pc_stall=0, io_wen=0, io_wdata=0, led_data=0, led_valid=0, busy=0. Synchronizer and debounce counter cleared.
- Button path:
  - Two-flop synchronizer feeds the debouncer.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any bounce.
  - press = rising edge of the debounced level, a one-cycle pulse.
- ecall_hit = (instruction == 32'h00000073) && (a7 == 4 || a7 == 5). Any other a7 value is ignored: no stall, no effect.
- pc_stall is combinational: (state==IDLE && ecall_hit && !suppress) || state in {OUT_WAIT, IN_WAIT, IN_WRITE}. The stall is therefore visible in the same cycle the ECALL is decoded.
- FSM, one transition per clk:
  - IDLE, ecall_hit, !suppress, a7==4: led_data <= a0_data, led_valid <= 1, go to OUT_WAIT.
  - IDLE, ecall_hit, !suppress, a7==5: go to IN_WAIT.
  - OUT_WAIT: on press, go to RELEASE. led_data and led_valid are kept until the next service-4 call or reset.
  - IN_WAIT: on press, io_wdata <= extend(sw) (see Optional Feature), go to IN_WRITE.
  - IN_WRITE: io_wen=1 for exactly this cycle, go to RELEASE.
  - RELEASE: pc_stall=0, suppress=1 for this cycle so the same ECALL is not re-taken while the PC advances. Go to IDLE.
- Edge timing:
  - A press asserted in the same cycle the ECALL is first decoded is ignored; only presses while in a WAIT state count.
  - A button still held from a previous call does not satisfy a new call; a new rising edge is required.
- Back-to-back ECALLs: the second one is accepted at the earliest in the cycle after RELEASE.
- Reset mid-operation: immediate IDLE. Any pending write is dropped and io_wen stays 0.
- Latency:
  - Service 4: ecall decode to stall release = time until press plus 1 cycle (RELEASE).
  - Service 5: press to io_wen = 1 cycle; io_wen to unstall = 1 cycle.

Optional Feature:
- Macro ECALL_IO_SIGNEXT_EN.
- Defined: extend(sw) sign-extends from bit SW_WIDTH-1 to 32 bits.
- Undefined: extend(sw) zero-extends to 32 bits.
- No other behaviour changes.

Decomposition:
- Shared package holds:
  - localparam ECALL_INSN = 32'h00000073
  - service codes SVC_PRINT_INT = 4 and SVC_READ_INT = 5
  - state encoding typedef (IDLE, OUT_WAIT, IN_WAIT, IN_WRITE, RELEASE) and register index A0_IDX = 10.
- One sub-module: btn_debounce (synchronizer, debouncer and rising-edge pulse), parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan (DEBOUNCE_CYCLES=4):
- Print: instruction=ECALL, a7=4, a0_data=32'h0000_00A5 -> pc_stall=1 that cycle; led_data=32'hA5 and led_valid=1 next cycle; press held for 10 cycles -> exactly one RELEASE cycle, then pc_stall=0.
- Read: a7=5, sw=16'h8001, press -> io_wen high for exactly 1 cycle with io_wdata=32'hFFFF_8001 if the macro is defined, else 32'h0000_8001.
- Bounce: confirm_btn toggling every 2 cycles for 20 cycles -> no press and FSM stays in IN_WAIT; then stable high for 4 or more cycles -> exactly one press.
- Non-I/O ECALL: a7=10 -> pc_stall=0, busy=0, io_wen never asserted.
- Reset in IN_WAIT: reset pulsed high -> state IDLE and all outputs 0 immediately; no io_wen after release of reset.
- Held button: press and keep the button high, then issue a second a7=5 ECALL after RELEASE -> stays stalled until the button is released and pressed again.

Source files
------------

// File: rtl/ecall_io_ctrl_pkg.sv
// Shared constants and state encoding for the ECALL I/O controller.
// Optional build macro ECALL_IO_SIGNEXT_EN is consumed in ecall_io_ctrl.sv.
package ecall_io_ctrl_pkg;

  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

  localparam logic [31:0] SVC_PRINT_INT = 32'd4;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;

  localparam logic [4:0] A0_IDX = 5'd10;

  typedef enum logic [2:0] {
    IDLE,
    OUT_WAIT,
    IN_WAIT,
    IN_WRITE,
    RELEASE
  } state_t;

endpackage

// File: rtl/ecall_io_ctrl_btn_debounce.sv
// Confirm button path: two-flop synchronizer, level debouncer
// and a one-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic [1:0]       sync;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      // any cycle agreeing with the current level restarts the count
      if (sync[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/ecall_io_ctrl.sv
// ECALL I/O controller: print-int to LEDs, read-int from switches.
// Define ECALL_IO_SIGNEXT_EN to sign-extend switches, else zero-extend.
module ecall_io_ctrl
  import ecall_io_ctrl_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0_data,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                confirm_btn,
  output logic                pc_stall,
  output logic                io_wen,
  output logic [31:0]         io_wdata,
  output logic [31:0]         led_data,
  output logic                led_valid,
  output logic                busy
);

  state_t      state;
  logic        press;
  logic        is_print;
  logic        is_read;
  logic        ecall_hit;
  logic        suppress;
  logic        take;
  logic [31:0] sw_ext;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .btn  (confirm_btn),
    .press(press)
  );

`ifdef ECALL_IO_SIGNEXT_EN
  assign sw_ext = 32'(signed'(sw));
`else
  assign sw_ext = 32'(sw);
`endif

  assign is_print  = (a7 == SVC_PRINT_INT);
  assign is_read   = (a7 == SVC_READ_INT);
  assign ecall_hit = (instruction == ECALL_INSN)
                   && (is_print || is_read);

  // the ECALL still sits in decode while the PC advances out of RELEASE
  assign suppress = (state == RELEASE);
  assign take     = (state == IDLE) && ecall_hit && !suppress;

  assign pc_stall = !reset && (take
                  || (state == OUT_WAIT)
                  || (state == IN_WAIT)
                  || (state == IN_WRITE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      io_wen    <= 1'b0;
      io_wdata  <= '0;
      led_data  <= '0;
      led_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      io_wen <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            busy <= 1'b1;
            if (is_print) begin
              led_data  <= a0_data;
              led_valid <= 1'b1;
              state     <= OUT_WAIT;
            end else begin
              state <= IN_WAIT;
            end
          end
        end
        OUT_WAIT: begin
          if (press) state <= RELEASE;
        end
        IN_WAIT: begin
          if (press) begin
            io_wdata <= sw_ext;
            io_wen   <= 1'b1;
            state    <= IN_WRITE;
          end
        end
        IN_WRITE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
